// File: rtl/lfsr_prbs_gen_chk_if.sv
// Handshake bundle for the PRBS generator/checker: generator controls and status,
// plus the checker's serial input and lock/error status.
interface lfsr_prbs_gen_chk_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] state;
    logic             prbs_out;
    logic             wrap;
    logic             seed_err;
    logic             chk_valid;
    logic             chk_bit;
    logic             locked;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, load, seed_in, chk_valid, chk_bit,
        input  state, prbs_out, wrap, seed_err, locked, err_cnt
    );

    modport slave (
        input  en, load, seed_in, chk_valid, chk_bit,
        output state, prbs_out, wrap, seed_err, locked, err_cnt
    );
endinterface

// File: rtl/lfsr_prbs_gen_chk.sv
// Fibonacci LFSR PRBS generator with a self-synchronising checker sharing the same taps.
// Checker states:  HUNT | filling chk_sr with WIDTH received bits
//                  LOCK | comparing each received bit against the tap prediction
module lfsr_prbs_gen_chk #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
    parameter logic [WIDTH-1:0] SEED     = '1,
    parameter int               CNT_W    = 16,
    parameter int               LOSS_THR = 4
) (
    input logic                 clk,
    input logic                 rst,
    lfsr_prbs_gen_chk_if.slave  prbs_if
);
    localparam int FILL_W = $clog2(WIDTH + 1);

    typedef enum logic {HUNT, LOCK} chk_state_t;

    logic [WIDTH-1:0]  state_q, start_q;
    logic              wrap_q, seed_err_q;
    logic              gen_fb;
    logic [WIDTH-1:0]  gen_step_d, load_val_d;

    chk_state_t        chk_state_q;
    logic [WIDTH-1:0]  chk_sr_q;
    logic [FILL_W-1:0] fill_q;
    logic [7:0]        miss_q;
    logic              locked_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic              pred;

    assign gen_fb     = ^(state_q & TAPS);
    assign gen_step_d = {state_q[WIDTH-2:0], gen_fb};
    // An all-zero load would freeze the LFSR, so it is replaced by SEED.
    assign load_val_d = (prbs_if.seed_in == '0) ? SEED : prbs_if.seed_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            start_q    <= SEED;
            wrap_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else if (prbs_if.load) begin
            state_q    <= load_val_d;
            start_q    <= load_val_d;
            seed_err_q <= (prbs_if.seed_in == '0);
            wrap_q     <= 1'b0;
        end else if (prbs_if.en) begin
            state_q    <= gen_step_d;
            wrap_q     <= (gen_step_d == start_q);
            seed_err_q <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end
    end

    assign pred = ^(chk_sr_q & TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_state_q <= HUNT;
            chk_sr_q    <= '0;
            fill_q      <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else if (prbs_if.chk_valid) begin
            // The received bit, never the prediction, is shifted in so a bit error
            // flushes out after WIDTH bits and the checker realigns on its own.
            chk_sr_q <= {chk_sr_q[WIDTH-2:0], prbs_if.chk_bit};
            case (chk_state_q)
                HUNT: begin
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        chk_state_q <= LOCK;
                        locked_q    <= 1'b1;
                        fill_q      <= '0;
                        miss_q      <= '0;
                    end else begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
                LOCK: begin
                    if (prbs_if.chk_bit == pred) begin
                        miss_q <= '0;
                    end else begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                        if (miss_q == 8'(LOSS_THR - 1)) begin
                            chk_state_q <= HUNT;
                            locked_q    <= 1'b0;
                            fill_q      <= '0;
                            miss_q      <= '0;
                        end else begin
                            miss_q <= miss_q + 8'd1;
                        end
                    end
                end
                default: begin
                    chk_state_q <= HUNT;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign prbs_if.state    = state_q;
    assign prbs_if.prbs_out = state_q[WIDTH-1];
    assign prbs_if.wrap     = wrap_q;
    assign prbs_if.seed_err = seed_err_q;
    assign prbs_if.locked   = locked_q;
    assign prbs_if.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Directed bench for lfsr_prbs_gen_chk with default parameters (WIDTH=4, TAPS=4'b1100).
module tb_lfsr_prbs_gen_chk;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] seq [16];

    always #5 clk = ~clk;

    lfsr_prbs_gen_chk_if #(.WIDTH(4), .CNT_W(16)) bus ();

    lfsr_prbs_gen_chk dut (
        .clk     (clk),
        .rst     (rst),
        .prbs_if (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.seed_in   = 4'h0;
        bus.chk_valid = 1'b0;
        bus.chk_bit   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_state", bus.state, 4'hF);
        check("rst_prbs", bus.prbs_out, 1'b1);
        check("rst_wrap", bus.wrap, 1'b0);
        check("rst_seed_err", bus.seed_err, 1'b0);
        check("rst_locked", bus.locked, 1'b0);
        check("rst_err_cnt", bus.err_cnt, 16'd0);

        // default seed walks the full period back to F
        bus.en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("t1_state_%0d", i), bus.state, seq[i]);
            check($sformatf("t1_wrap_%0d", i), bus.wrap, (i == 15));
        end
        bus.en = 1'b0;
        step();
        check("t1_idle_state", bus.state, 4'hF);
        check("t1_idle_wrap", bus.wrap, 1'b0);

        // load 9, wrap when the sequence returns to 9
        bus.load    = 1'b1;
        bus.seed_in = 4'h9;
        step();
        check("t2_load_state", bus.state, 4'h9);
        check("t2_load_seed_err", bus.seed_err, 1'b0);
        check("t2_load_wrap", bus.wrap, 1'b0);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("t2_state_%0d", i), bus.state, seq[(7 + i) % 15]);
            check($sformatf("t2_wrap_%0d", i), bus.wrap, (i == 15));
            check($sformatf("t2_seed_err_%0d", i), bus.seed_err, 1'b0);
        end
        bus.en = 1'b0;

        // zero seed replaced by SEED; load beats en
        bus.load    = 1'b1;
        bus.seed_in = 4'h0;
        step();
        check("t3_zero_state", bus.state, 4'hF);
        check("t3_zero_seed_err", bus.seed_err, 1'b1);
        bus.load = 1'b0;
        step();
        check("t3_seed_err_clear", bus.seed_err, 1'b0);
        check("t3_hold_state", bus.state, 4'hF);
        bus.load    = 1'b1;
        bus.en      = 1'b1;
        bus.seed_in = 4'h5;
        step();
        check("t3_load_en_state", bus.state, 4'h5);
        check("t3_load_en_seed_err", bus.seed_err, 1'b0);
        bus.load = 1'b0;

        // loopback: lock after 4 valid bits, then error-free
        bus.chk_valid = 1'b1;
        bus.chk_bit   = bus.prbs_out;
        for (int i = 1; i <= 4; i++) begin
            step();
            bus.chk_bit = bus.prbs_out;
            check($sformatf("t4_locked_%0d", i), bus.locked, (i == 4));
        end
        for (int i = 0; i < 100; i++) begin
            step();
            bus.chk_bit = bus.prbs_out;
            check($sformatf("t4_run_locked_%0d", i), bus.locked, 1'b1);
            check($sformatf("t4_run_err_%0d", i), bus.err_cnt, 16'd0);
        end

        // single inverted bit: 3-error self-sync burst, lock kept
        bus.chk_bit = ~bus.prbs_out;
        step();
        bus.chk_bit = bus.prbs_out;
        check("t5_err_first", bus.err_cnt, 16'd1);
        for (int i = 1; i <= 10; i++) begin
            step();
            bus.chk_bit = bus.prbs_out;
            check($sformatf("t5_locked_%0d", i), bus.locked, 1'b1);
            if (i == 2) check("t5_err_mid", bus.err_cnt, 16'd1);
            if (i == 3) check("t5_err_second", bus.err_cnt, 16'd2);
        end
        check("t5_err_final", bus.err_cnt, 16'd3);

        // known fill 0,1,0,1 then constant 0: four consecutive mismatches
        rst           = 1'b1;
        bus.chk_valid = 1'b0;
        bus.en        = 1'b0;
        step();
        rst = 1'b0;
        check("t6_rst_err", bus.err_cnt, 16'd0);
        check("t6_rst_locked", bus.locked, 1'b0);
        bus.en        = 1'b1;
        bus.chk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.chk_bit = i[0];
            step();
        end
        check("t6_locked", bus.locked, 1'b1);
        check("t6_lock_err", bus.err_cnt, 16'd0);
        bus.chk_valid = 1'b0;
        bus.chk_bit   = 1'b0;
        step();
        step();
        check("t6_freeze_err", bus.err_cnt, 16'd0);
        check("t6_freeze_locked", bus.locked, 1'b1);
        bus.chk_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("t6_zero_err_%0d", i), bus.err_cnt, i);
            check($sformatf("t6_zero_locked_%0d", i), bus.locked, (i < 4));
        end
        step();
        step();
        check("t6_hunt_err_held", bus.err_cnt, 16'd4);
        check("t6_hunt_locked", bus.locked, 1'b0);
        rst    = 1'b1;
        bus.en = 1'b0;
        step();
        rst = 1'b0;
        check("t6_rst2_locked", bus.locked, 1'b0);
        check("t6_rst2_err", bus.err_cnt, 16'd0);
        check("t6_rst2_state", bus.state, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
